fdtd_stream_engine: RTL and testbench

Streaming 1D FDTD update engine; next generation of the fixed-size buffer/ctrl/calc accelerator. Takes one field segment over a valid/ready stream, applies the Hy or Ez leapfrog update in parametrised fixed point with saturation, and streams results back to the data-memory mover. Runtime segment length, PEC boundaries, soft source injection and backpressure are all supported; no internal RAM.

---
 rtl/fdtd_pkg.sv | 33 +++
 rtl/fdtd_mac_sat.sv | 71 +++++++
 rtl/fdtd_stream_engine.sv | 202 ++++++++++++++++++++
 tb/tb_fdtd_stream_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fdtd_pkg.sv
// Shared types and helpers for the streaming 1D FDTD engine.
// State/mode enums and the generic signed saturation function.
package fdtd_pkg;

  localparam int SAT_W = 160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_HY = 1'b0,
    MODE_EZ = 1'b1
  } mode_e;

  // Clamp a wide signed value into a w-bit signed range.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fdtd_mac_sat.sv
// Two-stage c0*x0 + c1*x1 - c2*x2, >>> F, saturate to W bits.
// All stages freeze together when en_i is low.
module fdtd_mac_sat
  import fdtd_pkg::*;
#(
  parameter int W  = 32,
  parameter int F  = 16,
  parameter int TW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          vld_i,
  input  logic [TW-1:0] tag_i,
  input  logic [W-1:0]  c0_i,
  input  logic [W-1:0]  x0_i,
  input  logic [W-1:0]  c1_i,
  input  logic [W:0]    x1_i,
  input  logic [W-1:0]  c2_i,
  input  logic [W-1:0]  x2_i,
  input  logic          sub_i,
  output logic          vld_o,
  output logic [TW-1:0] tag_o,
  output logic [W-1:0]  data_o
);

  localparam int PW = 2 * W + 2;
  localparam int SW = PW + 2;

  logic signed [PW-1:0] p0_d, p1_d, p2_d;
  logic signed [PW-1:0] p0_q, p1_q, p2_q;
  logic signed [SW-1:0] sum_d, shf_d;
  logic [W-1:0]         sat_d;
  logic                 v1_q;
  logic [TW-1:0]        t1_q;

  // Products, then sum/shift/saturate of the registered products.
  always_comb begin
    p0_d = PW'($signed(c0_i)) * PW'($signed(x0_i));
    p1_d = PW'($signed(c1_i)) * PW'($signed(x1_i));
    p2_d = '0;
    if (sub_i) p2_d = -(PW'($signed(c2_i)) * PW'($signed(x2_i)));
    sum_d = SW'(p0_q) + SW'(p1_q) + SW'(p2_q);
    shf_d = sum_d >>> F;
    sat_d = W'(saturate(SAT_W'(shf_d), W));
  end

  // Both pipeline stages advance only when enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      t1_q   <= '0;
      p0_q   <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      vld_o  <= 1'b0;
      tag_o  <= '0;
      data_o <= '0;
    end else if (en_i) begin
      v1_q   <= vld_i;
      t1_q   <= tag_i;
      p0_q   <= p0_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      vld_o  <= v1_q;
      tag_o  <= t1_q;
      data_o <= sat_d;
    end
  end

endmodule

// File: rtl/fdtd_stream_engine.sv
// Streaming 1D FDTD Hy/Ez update engine with PEC edges and source.
// Optional probe capture port under `FDTD_SAMPLE_PROBE_EN.
module fdtd_stream_engine
  import fdtd_pkg::*;
#(
  parameter int FDTD_DATA_WIDTH   = 32,
  parameter int FRAC_WIDTH        = 16,
  parameter int BUFFER_ADDR_WIDTH = 10
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         start_i,
  input  logic                         mode_i,
  input  logic [BUFFER_ADDR_WIDTH:0]   size_i,
  input  logic                         src_en_i,
  input  logic [BUFFER_ADDR_WIDTH-1:0] src_idx_i,
`ifdef FDTD_SAMPLE_PROBE_EN
  input  logic [BUFFER_ADDR_WIDTH-1:0] probe_idx_i,
  output logic [FDTD_DATA_WIDTH-1:0]   sample_point_o,
`endif
  input  logic [FDTD_DATA_WIDTH-1:0]   ceze,
  input  logic [FDTD_DATA_WIDTH-1:0]   cezhy,
  input  logic [FDTD_DATA_WIDTH-1:0]   cezj,
  input  logic [FDTD_DATA_WIDTH-1:0]   chyh,
  input  logic [FDTD_DATA_WIDTH-1:0]   chyez,
  input  logic [FDTD_DATA_WIDTH-1:0]   Jz,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [FDTD_DATA_WIDTH-1:0]   in_self_i,
  input  logic [FDTD_DATA_WIDTH-1:0]   in_other_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [FDTD_DATA_WIDTH-1:0]   out_data_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] out_idx_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int W  = FDTD_DATA_WIDTH;
  localparam int AW = BUFFER_ADDR_WIDTH;
  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_e        state_q;
  mode_e         mode_q;
  logic [AW:0]   size_q;
  logic          src_en_q;
  logic [AW-1:0] src_idx_q;
  logic [AW:0]   in_cnt_q;
  logic [AW:0]   out_cnt_q;
  logic [W-1:0]  prev_q;
  logic          hold_v_q;
  logic [W-1:0]  hold_self_q;
  logic [W-1:0]  hold_other_q;
  logic [AW-1:0] hold_idx_q;
  logic          busy_q;
  logic          done_q;

  logic          adv, acc, out_hs, last_in, last_out, drain_iss;
  logic          iss_v, iss_src;
  logic [W-1:0]  iss_self;
  logic [W:0]    iss_diff;
  logic [AW-1:0] iss_idx;
  logic [W-1:0]  c0, c1;

  // Handshakes and issue selection: Ez issues on entry, Hy is skewed by one.
  always_comb begin
    adv        = !out_valid_o || out_ready_i;
    in_ready_o = (state_q == RUN) && adv;
    acc        = in_valid_i && in_ready_o;
    out_hs     = out_valid_o && out_ready_i;
    last_in    = (in_cnt_q + ONE) == size_q;
    last_out   = (out_cnt_q + ONE) == size_q;
    drain_iss  = (state_q == DRAIN) && adv && hold_v_q && (mode_q == MODE_HY);
    iss_v      = 1'b0;
    iss_src    = 1'b0;
    iss_self   = hold_self_q;
    iss_idx    = hold_idx_q;
    iss_diff   = '0;
    c0         = chyh;
    c1         = chyez;
    if (mode_q == MODE_EZ) begin
      c0       = ceze;
      c1       = cezhy;
      iss_v    = acc;
      iss_self = in_self_i;
      iss_idx  = in_cnt_q[AW-1:0];
      iss_src  = src_en_q && (in_cnt_q[AW-1:0] == src_idx_q);
      iss_diff = {in_other_i[W-1], in_other_i} - {prev_q[W-1], prev_q};
    end else if (acc) begin
      iss_v    = hold_v_q;
      iss_diff = {in_other_i[W-1], in_other_i}
               - {hold_other_q[W-1], hold_other_q};
    end else if (drain_iss) begin
      iss_v    = 1'b1;
      iss_diff = -{hold_other_q[W-1], hold_other_q};
    end
  end

  fdtd_mac_sat #(
    .W  (W),
    .F  (FRAC_WIDTH),
    .TW (AW)
  ) u_mac (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (adv),
    .vld_i  (iss_v),
    .tag_i  (iss_idx),
    .c0_i   (c0),
    .x0_i   (iss_self),
    .c1_i   (c1),
    .x1_i   (iss_diff),
    .c2_i   (cezj),
    .x2_i   (Jz),
    .sub_i  (iss_src),
    .vld_o  (out_valid_o),
    .tag_o  (out_idx_o),
    .data_o (out_data_o)
  );

  // Control FSM plus counters, Ez history and Hy skew register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      mode_q       <= MODE_HY;
      size_q       <= '0;
      src_en_q     <= 1'b0;
      src_idx_q    <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      prev_q       <= '0;
      hold_v_q     <= 1'b0;
      hold_self_q  <= '0;
      hold_other_q <= '0;
      hold_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start_i) begin
          mode_q    <= mode_e'(mode_i);
          size_q    <= size_i;
          src_en_q  <= src_en_i;
          src_idx_q <= src_idx_i;
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          prev_q    <= '0;
          hold_v_q  <= 1'b0;
          busy_q    <= 1'b1;
          if (size_i == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: if (acc && last_in) state_q <= DRAIN;
        DRAIN: if (out_hs && last_out) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (acc) begin
        in_cnt_q     <= in_cnt_q + ONE;
        prev_q       <= in_other_i;
        hold_v_q     <= 1'b1;
        hold_self_q  <= in_self_i;
        hold_other_q <= in_other_i;
        hold_idx_q   <= in_cnt_q[AW-1:0];
      end
      if (drain_iss) hold_v_q <= 1'b0;
      if (out_hs) out_cnt_q <= out_cnt_q + ONE;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef FDTD_SAMPLE_PROBE_EN
  logic [AW-1:0] probe_q;
  logic [W-1:0]  sample_q;

  // Capture the result whose index matches the latched probe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      probe_q  <= '0;
      sample_q <= '0;
    end else begin
      if (state_q == IDLE && start_i) probe_q <= probe_idx_i;
      if (out_hs && out_idx_o == probe_q) sample_q <= out_data_o;
    end
  end

  assign sample_point_o = sample_q;
`endif

endmodule

// File: tb/tb_fdtd_stream_engine.sv
// Directed self-checking bench for fdtd_stream_engine.
// Covers Ez/Hy updates, source, saturation, backpressure, resets.
module tb_fdtd_stream_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [10:0] size;
  logic        src_en;
  logic [9:0]  src_idx;
  logic [31:0] ceze, cezhy, cezj, chyh, chyez, jz;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_self, in_other;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [9:0]  out_idx;
  logic        busy;
  logic        done;
`ifdef FDTD_SAMPLE_PROBE_EN
  logic [9:0]  probe_idx;
  logic [31:0] sample_point;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] self_a  [0:64];
  logic [31:0] other_a [0:64];
  logic [31:0] exp_a   [0:63];
  logic [31:0] got_d   [0:63];
  logic [9:0]  got_i   [0:63];
  logic [31:0] ref_d   [0:63];
  int          nout, done_cyc, last_cyc;
  logic        timeout, busy0, saw_valid;

  fdtd_stream_engine dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .size_i      (size),
    .src_en_i    (src_en),
    .src_idx_i   (src_idx),
`ifdef FDTD_SAMPLE_PROBE_EN
    .probe_idx_i    (probe_idx),
    .sample_point_o (sample_point),
`endif
    .ceze        (ceze),
    .cezhy       (cezhy),
    .cezj        (cezj),
    .chyh        (chyh),
    .chyez       (chyez),
    .Jz          (jz),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_self_i   (in_self),
    .in_other_i  (in_other),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_seg(input logic m, input int n, input logic se,
                         input int sidx, input int stall);
    int ib;
    int cyc;
    timeout = 1'b0;
    saw_valid = 1'b0;
    nout = 0;
    done_cyc = -1;
    last_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    size = 11'(n);
    src_en = se;
    src_idx = 10'(sidx);
    @(negedge clk);
    start = 1'b0;
    ib = 0;
    cyc = 0;
    while (done_cyc < 0 && cyc < 5000) begin
      in_valid = (ib < n);
      in_self = self_a[ib];
      in_other = other_a[ib];
      out_ready = ($urandom_range(99) >= stall);
      #1;
      if (cyc == 0) busy0 = busy;
      if (out_valid) saw_valid = 1'b1;
      if (in_valid && in_ready) ib++;
      if (out_valid && out_ready) begin
        if (nout < 64) begin
          got_d[nout] = out_data;
          got_i[nout] = out_idx;
        end
        nout++;
        last_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (done_cyc < 0) timeout = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; mode = 1'b0; size = '0; src_en = 1'b0; src_idx = '0;
    ceze = '0; cezhy = '0; cezj = '0; chyh = '0; chyez = '0; jz = '0;
    in_valid = 1'b0; in_self = '0; in_other = '0; out_ready = 1'b1;
`ifdef FDTD_SAMPLE_PROBE_EN
    probe_idx = '0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (out_idx !== 10'h0) begin failures++; $display("FAIL rst_out_idx got=%h exp=0", out_idx); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ez_basic;
    ceze = 32'h0001_0000; cezhy = 32'h0001_0000; cezj = '0; jz = '0;
    for (int i = 0; i < 4; i++) self_a[i] = 32'((i + 1) << 16);
    other_a[0] = 32'h0; other_a[1] = 32'h1_0000;
    other_a[2] = 32'h3_0000; other_a[3] = 32'h6_0000;
    exp_a[0] = 32'h1_0000; exp_a[1] = 32'h3_0000;
    exp_a[2] = 32'h5_0000; exp_a[3] = 32'h7_0000;
    run_seg(1'b1, 4, 1'b0, 0, 0);
    checks++; if (timeout) begin failures++; $display("FAIL ez_timeout got=no_done exp=done"); end
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL ez_busy_run got=%b exp=1", busy0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ez_busy_end got=%b exp=0", busy); end
    checks++; if (nout !== 4) begin failures++; $display("FAIL ez_count got=%0d exp=4", nout); end
    for (int i = 0; i < 4 && i < nout; i++) begin
      checks++; if (got_d[i] !== exp_a[i]) begin failures++; $display("FAIL ez_data[%0d] got=%h exp=%h", i, got_d[i], exp_a[i]); end
      checks++; if (got_i[i] !== 10'(i)) begin failures++; $display("FAIL ez_idx[%0d] got=%0d exp=%0d", i, got_i[i], i); end
    end
    checks++; if (done_cyc !== last_cyc + 1) begin failures++; $display("FAIL ez_done_timing got=%0d exp=%0d", done_cyc, last_cyc + 1); end
  endtask

  task automatic test_hy_basic;
    chyh = 32'h0001_0000; chyez = 32'h0000_8000;
    for (int i = 0; i < 3; i++) self_a[i] = '0;
    other_a[0] = 32'h2_0000; other_a[1] = 32'h4_0000; other_a[2] = 32'h8_0000;
    exp_a[0] = 32'h0001_0000; exp_a[1] = 32'h0002_0000; exp_a[2] = 32'hFFFC_0000;
    run_seg(1'b0, 3, 1'b0, 0, 0);
    checks++; if (timeout) begin failures++; $display("FAIL hy_timeout got=no_done exp=done"); end
    checks++; if (nout !== 3) begin failures++; $display("FAIL hy_count got=%0d exp=3", nout); end
    for (int i = 0; i < 3 && i < nout; i++) begin
      checks++; if (got_d[i] !== exp_a[i]) begin failures++; $display("FAIL hy_data[%0d] got=%h exp=%h", i, got_d[i], exp_a[i]); end
      checks++; if (got_i[i] !== 10'(i)) begin failures++; $display("FAIL hy_idx[%0d] got=%0d exp=%0d", i, got_i[i], i); end
    end
  endtask

  task automatic test_ez_source;
    ceze = 32'h0001_0000; cezhy = 32'h0001_0000;
    cezj = 32'h0001_0000; jz = 32'h0003_0000;
    self_a[0] = '0; self_a[1] = '0; other_a[0] = '0; other_a[1] = '0;
    run_seg(1'b1, 2, 1'b1, 1, 0);
    checks++; if (nout !== 2) begin failures++; $display("FAIL src_count got=%0d exp=2", nout); end
    checks++; if (got_d[0] !== 32'h0) begin failures++; $display("FAIL src_data0 got=%h exp=0", got_d[0]); end
    checks++; if (got_d[1] !== 32'hFFFD_0000) begin failures++; $display("FAIL src_data1 got=%h exp=fffd0000", got_d[1]); end
    cezj = '0; jz = '0;
  endtask

  task automatic test_saturation;
    ceze = 32'h7FFF_FFFF; cezhy = '0;
    self_a[0] = 32'h7FFF_FFFF; self_a[1] = 32'h8000_0000;
    other_a[0] = '0; other_a[1] = '0;
    run_seg(1'b1, 2, 1'b0, 0, 0);
    checks++; if (nout !== 2) begin failures++; $display("FAIL sat_count got=%0d exp=2", nout); end
    checks++; if (got_d[0] !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sat_pos got=%h exp=7fffffff", got_d[0]); end
    checks++; if (got_d[1] !== 32'h8000_0000) begin failures++; $display("FAIL sat_neg got=%h exp=80000000", got_d[1]); end
  endtask

  task automatic test_backpressure;
    int d;
    ceze = 32'h0001_0000; cezhy = 32'h0000_8000;
    for (int i = 0; i < 64; i++) begin
      self_a[i] = 32'(i * 37 - 500);
      other_a[i] = 32'((i * i * 13) % 1001 - 300);
    end
    for (int i = 0; i < 64; i++) begin
      d = $signed(other_a[i]) - ((i == 0) ? 0 : $signed(other_a[i-1]));
      exp_a[i] = 32'($signed(self_a[i]) + (d >>> 1));
    end
    run_seg(1'b1, 64, 1'b0, 0, 0);
    checks++; if (nout !== 64) begin failures++; $display("FAIL bp_ref_count got=%0d exp=64", nout); end
    for (int i = 0; i < 64 && i < nout; i++) begin
      ref_d[i] = got_d[i];
      checks++; if (got_d[i] !== exp_a[i]) begin failures++; $display("FAIL bp_ref_data[%0d] got=%h exp=%h", i, got_d[i], exp_a[i]); end
    end
    run_seg(1'b1, 64, 1'b0, 0, 30);
    checks++; if (timeout) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (nout !== 64) begin failures++; $display("FAIL bp_count got=%0d exp=64", nout); end
    for (int i = 0; i < 64 && i < nout; i++) begin
      checks++; if (got_d[i] !== exp_a[i] || got_d[i] !== ref_d[i]) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_d[i], exp_a[i]); end
      checks++; if (got_i[i] !== 10'(i)) begin failures++; $display("FAIL bp_idx[%0d] got=%0d exp=%0d", i, got_i[i], i); end
    end
  endtask

  task automatic test_size0;
    run_seg(1'b1, 0, 1'b0, 0, 0);
    checks++; if (done_cyc !== 0) begin failures++; $display("FAIL size0_done got=%0d exp=0", done_cyc); end
    checks++; if (saw_valid !== 1'b0 || nout !== 0) begin failures++; $display("FAIL size0_no_out got=%0d exp=0", nout); end
  endtask

  task automatic test_reset_mid;
    ceze = 32'h0001_0000; cezhy = 32'h0001_0000;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; size = 11'd8; src_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_self = 32'((i + 3) << 16);
      in_other = 32'(i << 16);
      out_ready = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_idx !== 10'h0) begin failures++; $display("FAIL midrst_out got=%b/%h/%0d exp=0/0/0", out_valid, out_data, out_idx); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got=%b%b%b exp=000", busy, done, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_ez_basic();
  endtask

  initial begin
    test_reset();
    test_ez_basic();
    test_hy_basic();
    test_ez_source();
    test_saturation();
    test_backpressure();
    test_size0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
